// File: rtl/dmem_port_if.sv
// Bundle of the two issue lanes and the single memory port seen by dmem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              l0_req;
    logic              l0_we;
    logic [ADDR_W-1:0] l0_addr;
    logic [DATA_W-1:0] l0_wdata;
    logic              l1_req;
    logic              l1_we;
    logic [ADDR_W-1:0] l1_addr;
    logic [DATA_W-1:0] l1_wdata;
    logic              l0_gnt;
    logic              l1_gnt;
    logic              l0_rvalid;
    logic              l1_rvalid;
    logic [DATA_W-1:0] l0_rdata;
    logic [DATA_W-1:0] l1_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;

    modport slave (
        input  l0_req, l0_we, l0_addr, l0_wdata,
        input  l1_req, l1_we, l1_addr, l1_wdata,
        input  mem_rdata,
        output l0_gnt, l1_gnt, l0_rvalid, l1_rvalid, l0_rdata, l1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output l0_req, l0_we, l0_addr, l0_wdata,
        output l1_req, l1_we, l1_addr, l1_wdata,
        output mem_rdata,
        input  l0_gnt, l1_gnt, l0_rvalid, l1_rvalid, l0_rdata, l1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the two lanes of an issue bundle.
// Lane 0 wins a dual request; lane 1 is buffered and replayed the next cycle.
//
// state | meaning
// IDLE  | grant whichever lane requests; on a dual request grant lane 0 and buffer lane 1
// DEFER | replay the buffered lane 1 op, lane requests ignored
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    dmem_port_if.slave       bus,
    output logic [CNT_W-1:0] conflict_cnt
);
    typedef enum logic {IDLE, DEFER} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic              capture;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic              rv0_q;
    logic              rv1_q;
    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;

    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        bus.l0_gnt    = 1'b0;
        bus.l1_gnt    = 1'b0;
        bus.stall     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        // Reset masks the port outright so a deferred op can never leak out.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (bus.l0_req) begin
                        bus.l0_gnt    = 1'b1;
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = bus.l0_we;
                        bus.mem_addr  = bus.l0_addr;
                        bus.mem_wdata = bus.l0_wdata;
                        if (bus.l1_req) begin
                            capture   = 1'b1;
                            bus.stall = 1'b1;
                            state_d   = DEFER;
                        end
                    end else if (bus.l1_req) begin
                        bus.l1_gnt    = 1'b1;
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = bus.l1_we;
                        bus.mem_addr  = bus.l1_addr;
                        bus.mem_wdata = bus.l1_wdata;
                    end
                end
                DEFER: begin
                    bus.l1_gnt    = 1'b1;
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = buf_we;
                    bus.mem_addr  = buf_addr;
                    bus.mem_wdata = buf_wdata;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_we       <= 1'b0;
            buf_addr     <= '0;
            buf_wdata    <= '0;
            conflict_cnt <= '0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                buf_we    <= bus.l1_we;
                buf_addr  <= bus.l1_addr;
                buf_wdata <= bus.l1_wdata;
                if (conflict_cnt != CNT_MAX) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
            rv0_q <= bus.l0_gnt && !bus.mem_we;
            rv1_q <= bus.l1_gnt && !bus.mem_we;
            if (rv0_q) begin
                rd0_q <= bus.mem_rdata;
            end
            if (rv1_q) begin
                rd1_q <= bus.mem_rdata;
            end
        end
    end

    // Load data arrives from memory in the rvalid cycle; the registers hold it afterwards.
    assign bus.l0_rvalid = rv0_q;
    assign bus.l1_rvalid = rv1_q;
    assign bus.l0_rdata  = rv0_q ? bus.mem_rdata : rd0_q;
    assign bus.l1_rdata  = rv1_q ? bus.mem_rdata : rd1_q;
endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of the memory word address.
REQ-002 Parameter DATA_W, default 32, width of the memory data words.
REQ-003 Parameter CNT_W, default 16, width of the conflict counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 l0_req / l1_req  input  1  lane 0 / lane 1 memory-op request; lane 0 is the older instruction of the issue bundle.
REQ-007 l0_we / l1_we  input  1  1 = store, 0 = load.
REQ-008 l0_addr / l1_addr  input  ADDR_W  word address.
REQ-009 l0_wdata / l1_wdata  input  DATA_W  store data.
REQ-010 l0_gnt / l1_gnt  output  1  the lane's op is driven onto the memory port this cycle.
REQ-011 l0_rvalid / l1_rvalid  output  1  load data valid for the lane.
REQ-012 l0_rdata / l1_rdata  output  DATA_W  load data, registered.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid in the cycle after a read strobe.
REQ-018 stall  output  1  freezes issue; requesters hold their inputs while it is high.
REQ-019 conflict_cnt  output  CNT_W  number of dual-request conflicts since reset.

Function
REQ-020 The FSM SHALL have two states: IDLE and DEFER.
REQ-021 IDLE, exactly one lane requesting: that lane's gnt=1 and its op is driven combinationally to mem_*; mem_en=1; stall=0; next state IDLE.
REQ-022 IDLE, both lanes requesting: lane 0 is granted; lane 1's we/addr/wdata are captured into a defer buffer; stall=1; conflict_cnt increments; next state DEFER.
REQ-023 DEFER: the buffered lane 1 op drives mem_*; l1_gnt=1; mem_en=1; stall=0; l0_req/l1_req are ignored; next state IDLE.
REQ-024 Lane 0 always precedes lane 1, so program order is preserved; a lane 0 store followed by a lane 1 load to the same address returns the newly stored data.
REQ-025 IDLE with no request: mem_en=0, mem_we=0, gnts=0, stall=0.
REQ-026 A granted load SHALL assert that lane's rvalid for exactly one cycle, in the cycle after the grant, with rdata equal to mem_rdata in that cycle.
REQ-027 A granted store SHALL never assert rvalid.
REQ-028 At most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-029 Back-to-back: after DEFER the next bundle may be granted in the following cycle, giving a sustained rate of one memory op per cycle.
REQ-030 rdata SHALL hold its last value when rvalid=0.
REQ-031 conflict_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 mem_addr and mem_wdata SHALL be 0 whenever mem_en=0.

Reset
REQ-033 While reset=1 at a rising edge, the FSM SHALL go to IDLE, the defer buffer is cleared, and conflict_cnt=0.
REQ-034 In the cycle after reset is sampled, all outputs are 0: gnts, rvalids, rdata, mem_en, mem_we, mem_addr, mem_wdata, stall, conflict_cnt.
REQ-035 While reset=1, mem_en and mem_we SHALL be 0 combinationally, regardless of requests.
REQ-036 Reset asserted in DEFER drops the deferred op: no write reaches memory, and no rvalid is produced for that op.

Verification
REQ-037 Single load: l0 load to addr 0x19 with mem_rdata=25 -> l0_gnt in cycle 0; l0_rvalid=1 and l0_rdata=25 in cycle 1; stall=0 throughout.
REQ-038 Dual conflict: l0 store 0xA5 to addr 1 plus l1 load from addr 1 -> cycle 0 mem_we=1 with addr 1, stall=1; cycle 1 l1_gnt=1 and mem_we=0; cycle 2 l1_rvalid=1 with rdata 0xA5; conflict_cnt=1.
REQ-039 Lane 1 only: l1 store 7 to addr 0 -> l1_gnt=1, mem_we=1, mem_wdata=7, l0_gnt=0, no rvalid.
REQ-040 Reset in DEFER: conflict with an l1 store, then reset=1 in the DEFER cycle -> mem_we=0 that cycle, state IDLE, conflict_cnt=0.
REQ-041 Saturation: run CNT_W=4 with 20 consecutive conflicts -> conflict_cnt stops at 15.
REQ-042 Random two-lane stream checked against an in-order reference memory model: every returned load value matches the model, and each lane receives exactly one gnt per request.
